memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles a granted transaction may wait for ramstate ACCESS before abort.
REQ-002 Parameter ERRWORD, default 32'hBAD1BAD1, load value returned on an aborted transaction.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  system clock, rising edge.
REQ-005 nRST  in  1  asynchronous reset, asserted when 1.
REQ-006 iREN  in  1  instruction read request, cache side.
REQ-007 dREN / dWEN  in  1 each  data read / write request, cache side.
REQ-008 iaddr / daddr / dstore  in  32 each  instruction address, data address, data write word.
REQ-009 iwait / dwait  out  1 each  low for exactly the completion cycle of that side's transaction, else high.
REQ-010 iload / dload  out  32 each  read data, valid only when matching wait is low.
REQ-011 ramREN / ramWEN  out  1 each  RAM read / write strobe.
REQ-012 ramaddr / ramstore  out  32 each  RAM address, RAM write word.
REQ-013 ramload  in  32  RAM read data.
REQ-014 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-015 err  out  1  sticky abort flag.

Function
REQ-016 FSM states IDLE, DSERV, ISERV, ABORT; one transaction in flight at a time.
REQ-017 IDLE: data request (dREN|dWEN) wins over iREN, except when last completed grant was data and iREN is high -> ISERV (round-robin anti-starvation).
REQ-018 On grant: latch address, store word, and op (write if dWEN, even when dREN also high); clear timeout counter; last-grant register updated on completion.
REQ-019 DSERV/ISERV: ramREN/ramWEN/ramaddr/ramstore driven only from latched registers; in IDLE and ABORT all RAM strobes low, ramaddr/ramstore 0.
REQ-020 Completion: ramstate==ACCESS -> granted side's wait low that same cycle, load = ramload combinationally (writes: load 0); next state IDLE.
REQ-021 Minimum latency: request high in cycle N (IDLE) -> strobe cycle N+1 -> wait low at earliest in N+1; one idle cycle with strobes low between back-to-back transactions.
REQ-022 Timeout counter increments each serve cycle without ACCESS; width clog2(TIMEOUT)+1; reaching TIMEOUT, or ramstate==ERROR, -> ABORT.
REQ-023 ABORT (one cycle): granted side's wait low, load = ERRWORD, err set to 1; next state IDLE; err remains 1 until reset.
REQ-024 Requester deasserting during a transaction does not cancel it; completion pulse still issued and ignored.
REQ-025 Non-granted side's wait held high throughout; its load outputs 0.

Reset
REQ-026 While nRST=1: state IDLE, counter 0, last-grant = instruction, err 0, iwait=dwait=1, ramREN=ramWEN=0, all data/address outputs 0.
REQ-027 Reset asserted mid-transaction abandons it immediately; no completion pulse afterwards.

Structure
REQ-028 ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3), word_t (32 bit) and arb_state_t in shared package cpu_types_pkg.
REQ-029 Timeout counter is a sub-module timeout_counter (clear, enable, expired); remainder in memory_arbiter.

Verification
REQ-030 iREN, iaddr=0x40, ramstate ACCESS on first strobe cycle, ramload=0x1234 -> ramREN=1, ramaddr=0x40 in cycle 1, iwait=0, iload=0x1234 in cycle 1.
REQ-031 iREN and dWEN together, daddr=0x80, dstore=0xCAFE -> data first (ramWEN, 0x80, 0xCAFE), one idle cycle, then instruction served.
REQ-032 dREN held continuously plus iREN -> grants alternate D, I, D; instruction never waits more than one data transaction.
REQ-033 ramstate held BUSY 16 cycles -> ABORT, wait low one cycle, load 0xBAD1BAD1, err=1 and stays 1.
REQ-034 ramstate ERROR on cycle 3 of a read -> ABORT next cycle with same response as REQ-033.
REQ-035 nRST pulsed during BUSY read -> outputs at reset values, no wait-low pulse, next request served normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared word, RAM-state and arbiter-state types
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/timeout_counter.sv
// ============================================================================
// timeout_counter : counts serve cycles that did not see RAM ACCESS
// Rev 1.0
// ============================================================================
`default_nettype none

module timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    logic [c_CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + c_CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment would make the count reach TIMEOUT.
    assign expired_o = enable_i && (count_q == c_CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter : single-port RAM arbiter between instruction and data caches
// Rev 1.0
// ============================================================================
`default_nettype none

module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter word_t       ERRWORD = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     iaddr,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    arb_state_t state_q, state_d;
    word_t      addr_q;
    word_t      store_q;
    logic       wr_q;
    logic       side_data_q;
    logic       last_data_q;
    logic       err_q;

    logic       w_dreq;
    logic       w_grant;
    logic       w_grant_data;
    logic       w_done;
    logic       w_serving;
    logic       w_expired;

    assign w_dreq    = dREN | dWEN;
    assign w_serving = (state_q == DSERV) || (state_q == ISERV);

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (CLK),
        .rst       (nRST),
        .clear_i   (state_q == IDLE),
        .enable_i  (w_serving && (ramstate != ACCESS)),
        .expired_o (w_expired)
    );

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            store_q     <= '0;
            wr_q        <= 1'b0;
            side_data_q <= 1'b0;
            last_data_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_grant) begin
                addr_q      <= w_grant_data ? daddr : iaddr;
                store_q     <= w_grant_data ? dstore : '0;
                wr_q        <= w_grant_data & dWEN;
                side_data_q <= w_grant_data;
            end
            if (w_done) begin
                last_data_q <= side_data_q;
            end
            if (state_q == ABORT) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_done       = 1'b0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state_q)
            IDLE: begin
                // Data has priority unless it won last time and fetch is waiting.
                if (iREN && (!w_dreq || last_data_q)) begin
                    state_d = ISERV;
                    w_grant = 1'b1;
                end else if (w_dreq) begin
                    state_d      = DSERV;
                    w_grant      = 1'b1;
                    w_grant_data = 1'b1;
                end
            end
            DSERV, ISERV: begin
                ramREN   = ~wr_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    w_done  = 1'b1;
                    if (side_data_q) begin
                        dwait = 1'b0;
                        dload = wr_q ? '0 : ramload;
                    end else begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end else if ((ramstate == ERROR) || w_expired) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                state_d = IDLE;
                w_done  = 1'b1;
                if (side_data_q) begin
                    dwait = 1'b0;
                    dload = ERRWORD;
                end else begin
                    iwait = 1'b0;
                    iload = ERRWORD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err = err_q | (state_q == ABORT);

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// tb_memory_arbiter : directed scoreboard bench for memory_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        bit    is_data;
        word_t load;
    } resp_t;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait;
    word_t     iload, dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      err;

    int    n_cmp = 0;
    int    n_mis = 0;
    resp_t sb_q[$];

    memory_arbiter #(
        .TIMEOUT (16),
        .ERRWORD (32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .iaddr    (iaddr),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic drive_slot();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    // Completion monitor: every wait-low pulse must match the oldest expected response.
    always @(negedge CLK) begin
        if (!nRST && (iwait === 1'b0 || dwait === 1'b0)) begin
            if (sb_q.size() == 0) begin
                chk("spurious_pulse", {30'd0, iwait, dwait}, 32'd3);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                chk("pulse_side", {31'd0, ~dwait}, {31'd0, e.is_data});
                if (e.is_data) begin
                    chk("dload", dload, e.load);
                    chk("iwait_held", {31'd0, iwait}, 32'd1);
                    chk("iload_zero", iload, 32'd0);
                end else begin
                    chk("iload", iload, e.load);
                    chk("dwait_held", {31'd0, dwait}, 32'd1);
                    chk("dload_zero", dload, 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset values
        sample();
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_loads", iload | dload | ramstore, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        drive_slot();
        nRST = 1'b0;

        // Instruction read with zero-wait RAM
        drive_slot();
        iREN = 1; iaddr = 32'h40;
        sb_q.push_back('{is_data: 1'b0, load: 32'h1234});
        sample();
        chk("t1_idle_ren", {31'd0, ramREN}, 32'd0);
        drive_slot();
        iREN = 0; ramstate = ACCESS; ramload = 32'h1234;
        sample();
        chk("t1_ramREN", {31'd0, ramREN}, 32'd1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        chk("t1_iwait", {31'd0, iwait}, 32'd0);
        drive_slot();
        ramstate = FREE;
        sample();
        chk("t1_after_iwait", {31'd0, iwait}, 32'd1);

        // Simultaneous fetch and store: data wins, one idle cycle, then fetch
        drive_slot();
        iREN = 1; dWEN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h80; dstore = 32'hCAFE;
        sb_q.push_back('{is_data: 1'b1, load: 32'h0});
        sb_q.push_back('{is_data: 1'b0, load: 32'h5555});
        drive_slot();
        dWEN = 0; dREN = 0; ramstate = ACCESS; ramload = 32'h5555;
        sample();
        chk("t2_ramWEN", {30'd0, ramREN, ramWEN}, 32'd1);
        chk("t2_ramaddr", ramaddr, 32'h80);
        chk("t2_ramstore", ramstore, 32'hCAFE);
        drive_slot();
        sample();
        chk("t2_gap_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        drive_slot();
        iREN = 0;
        sample();
        chk("t2_i_ramREN", {30'd0, ramREN, ramWEN}, 32'd2);
        chk("t2_i_ramaddr", ramaddr, 32'h44);
        chk("t2_i_ramstore", ramstore, 32'd0);
        drive_slot();
        ramstate = FREE;

        // Continuous data reads plus fetch: grants alternate D, I, D
        drive_slot();
        dREN = 1; iREN = 1; daddr = 32'h100; iaddr = 32'h200;
        ramstate = ACCESS; ramload = 32'h77;
        sb_q.push_back('{is_data: 1'b1, load: 32'h77});
        sb_q.push_back('{is_data: 1'b0, load: 32'h77});
        sb_q.push_back('{is_data: 1'b1, load: 32'h77});
        for (int k = 1; k <= 5; k++) begin
            drive_slot();
            if (k == 5) begin
                dREN = 0; iREN = 0;
            end
            sample();
            if (k == 1 || k == 5) chk("t3_addr_d", ramaddr, 32'h100);
            else if (k == 3)      chk("t3_addr_i", ramaddr, 32'h200);
            else                  chk("t3_gap", {30'd0, ramREN, ramWEN}, 32'd0);
        end
        drive_slot();
        ramstate = FREE;

        // RAM stays BUSY: abort after TIMEOUT serve cycles
        drive_slot();
        dREN = 1; daddr = 32'h300; ramstate = BUSY;
        sb_q.push_back('{is_data: 1'b1, load: 32'hBAD1BAD1});
        for (int k = 1; k <= 18; k++) begin
            drive_slot();
            dREN = 0;
            sample();
            if (k == 1)  chk("t4_first_ren", {31'd0, ramREN}, 32'd1);
            if (k == 16) begin
                chk("t4_last_ren", {31'd0, ramREN}, 32'd1);
                chk("t4_err_before", {31'd0, err}, 32'd0);
            end
            if (k == 17) begin
                chk("t4_abort_dwait", {31'd0, dwait}, 32'd0);
                chk("t4_abort_ren", {31'd0, ramREN}, 32'd0);
                chk("t4_abort_err", {31'd0, err}, 32'd1);
            end
            if (k == 18) chk("t4_err_sticky", {31'd0, err}, 32'd1);
        end
        ramstate = FREE;

        // ERROR on third serve cycle of a fetch
        drive_slot();
        iREN = 1; iaddr = 32'h400; ramstate = BUSY;
        sb_q.push_back('{is_data: 1'b0, load: 32'hBAD1BAD1});
        for (int k = 1; k <= 5; k++) begin
            drive_slot();
            iREN = 0;
            ramstate = (k == 3) ? ERROR : BUSY;
            sample();
            if (k == 3) chk("t5_ren_c3", {31'd0, ramREN}, 32'd1);
            if (k == 4) begin
                chk("t5_abort_iwait", {31'd0, iwait}, 32'd0);
                chk("t5_abort_ren", {31'd0, ramREN}, 32'd0);
            end
            if (k == 5) chk("t5_err", {31'd0, err}, 32'd1);
        end
        ramstate = FREE;

        // Reset during a BUSY read: no pulse, then normal service
        drive_slot();
        dREN = 1; daddr = 32'h500; ramstate = BUSY;
        drive_slot();
        dREN = 0;
        drive_slot();
        nRST = 1'b1;
        sample();
        chk("t6_rst_ren", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("t6_rst_waits", {30'd0, iwait, dwait}, 32'd3);
        chk("t6_rst_err", {31'd0, err}, 32'd0);
        chk("t6_rst_addr", ramaddr, 32'd0);
        drive_slot();
        nRST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_slot();
            sample();
            chk("t6_quiet", {30'd0, iwait, dwait}, 32'd3);
        end
        drive_slot();
        dREN = 1; daddr = 32'h600;
        sb_q.push_back('{is_data: 1'b1, load: 32'h9999});
        drive_slot();
        dREN = 0; ramstate = ACCESS; ramload = 32'h9999;
        sample();
        chk("t6_ramaddr", ramaddr, 32'h600);
        chk("t6_dwait", {31'd0, dwait}, 32'd0);
        drive_slot();
        ramstate = FREE;
        drive_slot();
        sample();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
